ffmul_digit_serial: RTL and testbench

//   Digit-serial GF(2^m) polynomial-basis multiplier behind el2_exu_custom_ctl.

---
 rtl/ffmul_digit_serial.sv | 170 +++++++++++++++++
 tb/tb_ffmul_digit_serial.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ffmul_digit_serial.sv
// ffmul_digit_serial: digit-serial GF(2^m) multiplier over four trinomial fields, MSB-first.
// Optional build macro FFMUL_EARLY_EXIT_EN skips leading all-zero digits of b.
`default_nettype none

module ffmul_digit_serial #(
  parameter int DIGIT = 8,
  parameter int M_MAX = 409
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [M_MAX-1:0] a_i,
  input  logic [M_MAX-1:0] b_i,
  input  logic [1:0]       op_i,
  input  logic             enable_i,
  output logic [M_MAX-1:0] result_o,
  output logic             busy_o,
  output logic             finish_o,
  output logic             finish_p_o
);

  localparam int NMAX = (M_MAX + DIGIT - 1) / DIGIT;
  localparam int CW   = (NMAX > 1) ? $clog2(NMAX) : 1;
  localparam int PADW = NMAX * DIGIT;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  function automatic int field_deg(input logic [1:0] op);
    case (op)
      2'd0:    return 409;
      2'd1:    return 233;
      2'd2:    return 193;
      default: return 113;
    endcase
  endfunction

  function automatic int field_k(input logic [1:0] op);
    case (op)
      2'd0:    return 87;
      2'd1:    return 74;
      2'd2:    return 15;
      default: return 9;
    endcase
  endfunction

  function automatic logic [M_MAX-1:0] field_mask(input logic [1:0] op);
    logic [M_MAX-1:0] m;
    for (int i = 0; i < M_MAX; i++) m[i] = (i < field_deg(op));
    return m;
  endfunction

  function automatic logic [M_MAX-1:0] field_top(input logic [1:0] op);
    logic [M_MAX-1:0] t;
    for (int i = 0; i < M_MAX; i++) t[i] = (i == field_deg(op) - 1);
    return t;
  endfunction

  // x^m folds back onto x^k + 1
  function automatic logic [M_MAX-1:0] field_red(input logic [1:0] op);
    logic [M_MAX-1:0] r;
    for (int i = 0; i < M_MAX; i++) r[i] = (i == field_k(op)) || (i == 0);
    return r;
  endfunction

  function automatic logic [CW-1:0] last_digit(input logic [1:0] op);
    return CW'((field_deg(op) + DIGIT - 1) / DIGIT - 1);
  endfunction

  state_t           state;
  logic [M_MAX-1:0] a_r, b_r, acc;
  logic [1:0]       op_r;
  logic [CW-1:0]    cnt;

  logic [M_MAX-1:0] run_mask, run_top, run_red, acc_next, b_cap, cap_mask;
  logic [PADW-1:0]  b_pad;
  logic [DIGIT-1:0] digit;
  logic [CW-1:0]    start_cnt;

  assign run_mask = field_mask(op_r);
  assign run_top  = field_top(op_r);
  assign run_red  = field_red(op_r);
  assign cap_mask = field_mask(op_i);
  assign b_cap    = b_i & cap_mask;
  assign b_pad    = PADW'(b_r);
  assign digit    = b_pad[int'(cnt) * DIGIT +: DIGIT];

  // Horner over the digit bits: acc*x^DIGIT + a*digit, reduced one shift at a time
  always_comb begin
    logic [M_MAX-1:0] t;
    logic             top;
    t = acc;
    for (int j = DIGIT - 1; j >= 0; j--) begin
      top = |(t & run_top);
      t   = ((t << 1) & run_mask) ^ (top ? run_red : '0);
      if (digit[j]) t = t ^ a_r;
    end
    acc_next = t;
  end

`ifdef FFMUL_EARLY_EXIT_EN
  logic [PADW-1:0] b_cap_pad;
  assign b_cap_pad = PADW'(b_cap);
  always_comb begin
    start_cnt = '0;
    for (int i = 0; i < NMAX; i++)
      if (|b_cap_pad[i*DIGIT +: DIGIT]) start_cnt = CW'(i);
  end
`else
  always_comb begin
    start_cnt = last_digit(op_i);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      acc        <= '0;
      op_r       <= '0;
      cnt        <= '0;
      result_o   <= '0;
      busy_o     <= 1'b0;
      finish_o   <= 1'b0;
      finish_p_o <= 1'b0;
    end else begin
      finish_p_o <= 1'b0;
      case (state)
        IDLE: begin
          finish_o <= 1'b0;
          if (enable_i) begin
            state  <= RUN;
            busy_o <= 1'b1;
            a_r    <= a_i & cap_mask;
            b_r    <= b_cap;
            op_r   <= op_i;
            cnt    <= start_cnt;
            acc    <= '0;
          end
        end
        RUN: begin
          if (!enable_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            acc <= acc_next;
            if (cnt == '0) begin
              state      <= DONE;
              busy_o     <= 1'b0;
              result_o   <= acc_next;
              finish_o   <= 1'b1;
              finish_p_o <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        DONE: begin
          if (!enable_i) begin
            state    <= IDLE;
            finish_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ffmul_digit_serial.sv
// Scoreboard bench for ffmul_digit_serial: directed jobs, abort, mid-run reset.
`default_nettype none

module tb_ffmul_digit_serial;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [408:0] a_i = '0, b_i = '0, result_o;
  logic [1:0]   op_i = '0;
  logic         enable_i = 1'b0;
  logic         busy_o, finish_o, finish_p_o;

  ffmul_digit_serial #(.DIGIT(8), .M_MAX(409)) dut (
    .clk(clk), .rst(rst), .a_i(a_i), .b_i(b_i), .op_i(op_i), .enable_i(enable_i),
    .result_o(result_o), .busy_o(busy_o), .finish_o(finish_o), .finish_p_o(finish_p_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [408:0] res;
    int           lat;
    int           start;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           n_chk = 0, n_pass = 0;
  int           run_len = 0, last_len = 0;
  logic [408:0] last_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [408:0] act, input logic [408:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int fdeg(input logic [1:0] op);
    case (op)
      2'd0: return 409; 2'd1: return 233; 2'd2: return 193; default: return 113;
    endcase
  endfunction

  function automatic int fk(input logic [1:0] op);
    case (op)
      2'd0: return 87; 2'd1: return 74; 2'd2: return 15; default: return 9;
    endcase
  endfunction

  // schoolbook product followed by top-down trinomial reduction
  function automatic logic [408:0] gf_mul(input logic [408:0] a, input logic [408:0] b,
                                          input logic [1:0] op);
    logic [817:0] p, aa;
    int m, k;
    m = fdeg(op); k = fk(op);
    p = '0; aa = '0;
    for (int i = 0; i < m; i++) aa[i] = a[i];
    for (int i = 0; i < m; i++) if (b[i]) p = p ^ (aa << i);
    for (int i = 2*m - 2; i >= m; i--)
      if (p[i]) begin
        p[i] = 1'b0; p[i-m+k] = ~p[i-m+k]; p[i-m] = ~p[i-m];
      end
    return p[408:0];
  endfunction

  function automatic int exp_lat(input logic [408:0] b, input logic [1:0] op);
    int n;
    n = (fdeg(op) + 7) / 8;
`ifdef FFMUL_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < fdeg(op); i++) if (b[i]) n = i / 8 + 1;
`endif
    return n;
  endfunction

  // monitor: pops one expectation per completion pulse
  always @(negedge clk) begin
    exp_t e;
    if (busy_o) run_len++;
    else begin
      if (run_len != 0) last_len = run_len;
      run_len = 0;
    end
    if (finish_p_o) begin
      if (sb.size() == 0) chk("unexpected_pulse", 409'(1), 409'(0));
      else begin
        e = sb.pop_front();
        chk("result", result_o, e.res);
        chk("latency", 409'(cyc - e.start), 409'(e.lat));
        chk("busy_len", 409'(last_len), 409'(e.lat));
      end
    end
  end

  task automatic start_job(input logic [408:0] a, input logic [408:0] b, input logic [1:0] op,
                           input logic [408:0] exp, input bit push);
    exp_t e;
    @(negedge clk);
    a_i = a; b_i = b; op_i = op; enable_i = 1'b1;
    if (push) begin
      e.res = exp; e.lat = exp_lat(b, op); e.start = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    a_i = ~a; b_i = ~b; op_i = op ^ 2'd1;
  endtask

  task automatic finish_job(input string name, input logic [408:0] exp);
    for (int i = 0; i < 200 && !finish_o; i++) @(negedge clk);
    chk({name, "_done_seen"}, 409'(finish_o), 409'(1));
    @(negedge clk);
    chk({name, "_pulse_one_cycle"}, 409'(finish_p_o), 409'(0));
    chk({name, "_finish_level"}, 409'(finish_o), 409'(1));
    enable_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({name, "_finish_clear"}, 409'(finish_o), 409'(0));
    chk({name, "_result_held"}, result_o, exp);
    last_exp = exp;
  endtask

  task automatic job(input string name, input logic [408:0] a, input logic [408:0] b,
                     input logic [1:0] op, input logic [408:0] exp);
    start_job(a, b, op, exp, 1'b1);
    finish_job(name, exp);
  endtask

  initial begin
    logic [408:0] ra, rb, one, v;
    one = 409'(1);
    repeat (3) @(negedge clk);
    chk("rst_result", result_o, '0);
    chk("rst_busy", 409'(busy_o), '0);
    chk("rst_finish", 409'(finish_o), '0);
    chk("rst_pulse", 409'(finish_p_o), '0);
    rst = 1'b0;

    job("t1_ff113", one, one, 2'd3, one);
    v = '0; v[87] = 1'b1; v[0] = 1'b1;
    job("t2_ff409", one << 408, one << 1, 2'd0, v);
    v = '0; v[231] = 1'b1; v[146] = 1'b1; v[72] = 1'b1;
    job("t3_ff233", one << 232, one << 232, 2'd1, v);
    job("t4_ff193", (one << 300) | one, one, 2'd2, one);
    job("b_zero", one << 100, '0, 2'd3, '0);

    for (int i = 0; i < 409; i++) begin
      ra[i] = 1'($urandom_range(1, 0));
      rb[i] = 1'($urandom_range(1, 0));
    end
    rb[408] = 1'b1;
    start_job(ra, rb, 2'd0, '0, 1'b0);
    repeat (9) @(negedge clk);
    enable_i = 1'b0;
    repeat (60) @(negedge clk);
    chk("abort_result", result_o, last_exp);
    chk("abort_busy", 409'(busy_o), '0);
    chk("abort_finish", 409'(finish_o), '0);
    job("t5_random", ra, rb, 2'd0, gf_mul(ra, rb, 2'd0));

    start_job(rb, ra, 2'd0, '0, 1'b0);
    repeat (19) @(negedge clk);
    rst = 1'b1; enable_i = 1'b0;
    #1;
    chk("midrst_result", result_o, '0);
    chk("midrst_busy", 409'(busy_o), '0);
    chk("midrst_finish", 409'(finish_o | finish_p_o), '0);
    @(negedge clk);
    rst = 1'b0;
    job("t6_after_rst", rb, ra, 2'd3, gf_mul(rb, ra, 2'd3));

    repeat (5) @(negedge clk);
    chk("sb_empty", 409'(sb.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
